// File: rtl/key_expansion.sv
// AES-128 key schedule: expands a 128-bit cipher key into 44 round-key words on one registered bus.
// Latency: 1 cycle from key to w; a new key is accepted every cycle.
// Backpressure: none; the output register loads unconditionally every cycle (rst forces zero).

// Forward AES S-box as a pure combinational constant lookup.
module key_expansion_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Byte b of the table lives at bits [2047-8b -: 8]; 2047-8b == {~b, 3'b111}.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] msb_idx;

    assign msb_idx = {~din, 3'b111};
    assign dout    = SBOX_TABLE[msb_idx -: 8];
endmodule

module key_expansion (
    input  logic          clk,
    input  logic          rst,
    input  logic [127:0]  key,
    output logic [1407:0] w
);
    // Round constants for rounds 1..10, round r in bits [87-8r -: 8].
    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    logic [31:0]   words [44];
    logic [1407:0] expansion;

    assign words[0] = key[127:96];
    assign words[1] = key[95:64];
    assign words[2] = key[63:32];
    assign words[3] = key[31:0];

    // Ten chained rounds; each round derives four words from the previous four.
    for (genvar r = 1; r <= 10; r++) begin : g_round
        logic [31:0] rot;
        logic [31:0] sub;
        logic [31:0] temp;

        // RotWord: rotate one byte left, MSB byte moves to the bottom.
        assign rot = {words[4*r-1][23:0], words[4*r-1][31:24]};

        for (genvar b = 0; b < 4; b++) begin : g_sbox
            key_expansion_sbox u_sbox (
                .din  (rot[8*b +: 8]),
                .dout (sub[8*b +: 8])
            );
        end

        assign temp = sub ^ {RCON[87-8*r -: 8], 24'h0};

        assign words[4*r]   = words[4*r-4] ^ temp;
        assign words[4*r+1] = words[4*r-3] ^ words[4*r];
        assign words[4*r+2] = words[4*r-2] ^ words[4*r+1];
        assign words[4*r+3] = words[4*r-1] ^ words[4*r+2];
    end

    // Word 0 sits at the top of the bus, word 43 at the bottom.
    for (genvar i = 0; i < 44; i++) begin : g_flat
        assign expansion[1407-32*i -: 32] = words[i];
    end

    // Output register: reset to zero, otherwise capture the full expansion every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            w <= '0;
        end else begin
            w <= expansion;
        end
    end
endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: scoreboard queue fed by the driver, drained by a monitor.
// Reference model builds the S-box from GF(2^8) inversion plus the affine map, then runs the key schedule.
// Known FIPS-197 / Kung Fu / zero-key words are spot-checked on top of full-bus comparison.
module tb_key_expansion;
    logic          clk;
    logic          rst;
    logic [127:0]  key;
    logic [1407:0] w;

    int n_checks;
    int n_fails;

    logic [1407:0] exp_q [$];
    int            tag_q [$];

    logic [7:0] sbox_ref [256];

    typedef struct {
        int          tag;
        int          idx;
        logic [31:0] word;
    } spot_t;

    spot_t spots [$];

    key_expansion dut (
        .clk (clk),
        .rst (rst),
        .key (key),
        .w   (w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv;
        logic [7:0] x;
        logic [7:0] y;
        for (int v = 0; v < 256; v++) begin
            x   = v[7:0];
            inv = 8'h00;
            if (x != 0) begin
                for (int u = 1; u < 256; u++) begin
                    y = u[7:0];
                    if (gmul(x, y) == 8'h01) inv = y;
                end
            end
            sbox_ref[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   ws [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] bus;
        for (int i = 0; i < 4; i++) ws[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = ws[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            ws[i] = ws[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) bus[1407-32*i -: 32] = ws[i];
        return bus;
    endfunction

    task automatic add_spot(input int tag, input int idx, input logic [31:0] word);
        spot_t s;
        s.tag  = tag;
        s.idx  = idx;
        s.word = word;
        spots.push_back(s);
    endtask

    // Apply inputs before the next rising edge and record what that edge must produce.
    task automatic step(input logic r, input logic [127:0] k, input int tag);
        rst = r;
        key = k;
        exp_q.push_back(r ? '0 : expand(k));
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    // Monitor: after every rising edge, compare w with the oldest outstanding expectation.
    initial begin
        logic [1407:0] e;
        int            tg;
        int            bad;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                tg = tag_q.pop_front();
                n_checks++;
                if (w !== e) begin
                    bad = -1;
                    for (int i = 43; i >= 0; i--)
                        if (w[1407-32*i -: 32] !== e[1407-32*i -: 32]) bad = i;
                    n_fails++;
                    if (bad < 0) bad = 0;
                    $display("FAIL full_bus t=%0t first bad word %0d: got %h expected %h",
                             $time, bad, w[1407-32*bad -: 32], e[1407-32*bad -: 32]);
                end
                foreach (spots[j]) begin
                    if (spots[j].tag == tg) begin
                        n_checks++;
                        if (w[1407-32*spots[j].idx -: 32] !== spots[j].word) begin
                            n_fails++;
                            $display("FAIL spot tag%0d w[%0d]: got %h expected %h", tg,
                                     spots[j].idx, w[1407-32*spots[j].idx -: 32], spots[j].word);
                        end
                    end
                end
            end
        end
    end

    localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_KUNG  = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] K_ONES  = {128{1'b1}};
    localparam logic [127:0] K_ZERO  = 128'h0;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        key = K_ONES;
        build_sbox();

        add_spot(1, 0, 32'h2b7e1516);
        add_spot(1, 4, 32'ha0fafe17);
        add_spot(1, 5, 32'h88542cb1);
        add_spot(1, 40, 32'hd014f9a8);
        add_spot(1, 43, 32'hb6630ca6);
        add_spot(2, 4, 32'he232fcf1);
        add_spot(2, 5, 32'h91129188);
        add_spot(2, 6, 32'hb159e4e6);
        add_spot(2, 7, 32'hd679a293);
        add_spot(2, 8, 32'h56082007);
        add_spot(2, 20, 32'hb1293b33);
        add_spot(2, 40, 32'h28fddef8);
        add_spot(2, 41, 32'h6da4244a);
        add_spot(2, 42, 32'hccc0a4fe);
        add_spot(2, 43, 32'h3b316f26);
        for (int i = 0; i < 4; i++) add_spot(3, i, 32'h0);
        for (int i = 4; i < 8; i++) add_spot(3, i, 32'h62636363);
        add_spot(3, 40, 32'hb4ef5bcb);
        add_spot(3, 41, 32'h3e92e211);
        add_spot(3, 42, 32'h23e951cf);
        add_spot(3, 43, 32'h6f8f188e);

        // Reset with all-ones key, then release and load all-ones.
        step(1'b1, K_ONES, 0);
        step(1'b0, K_ONES, 0);
        // Individual vectors, reset in between, then back-to-back keys.
        step(1'b0, K_FIPS, 1);
        step(1'b1, K_KUNG, 0);
        step(1'b0, K_KUNG, 2);
        step(1'b0, K_ZERO, 3);
        step(1'b0, K_ZERO, 3);
        step(1'b0, K_FIPS, 1);
        step(1'b0, K_KUNG, 2);
        step(1'b0, K_ZERO, 3);

        // Random keys, one per cycle, with occasional reset pulses.
        for (int n = 0; n < 1000; n++) begin
            step($urandom_range(0, 19) == 0, {$urandom, $urandom, $urandom, $urandom}, 0);
        end

        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
